// File: rtl/mdu_iter.sv
// mdu_iter: HI/LO multiply/divide unit with pipelined multiply and radix-2 restoring divide.
// Define MDU_DIVZERO_EN for early divide-by-zero completion and a sticky div_zero flag.
module mdu_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Req,
  input  logic [3:0]       MDUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
`ifdef MDU_DIVZERO_EN
  , output logic           div_zero
`endif
);
  localparam int CW = $clog2(WIDTH + MUL_LAT) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] pipe [MUL_LAT];
  logic [WIDTH-1:0] rem, quo, dvs, dvd, q_fin, r_fin;
  logic neg_q, neg_r, dz;
  logic accept, is_mul, mul_s, is_madd, is_msub, is_div, sa, sb, b_zero, early_dz, ge;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, mul_res;
  logic [WIDTH:0] shifted, diff;
  assign accept  = state == IDLE && !Req;
  assign is_mul  = MDUControl inside {4'd1, 4'd2, [4'd7:4'd10]};
  assign mul_s   = MDUControl inside {4'd1, 4'd7, 4'd9};
  assign is_madd = MDUControl inside {4'd7, 4'd8};
  assign is_msub = MDUControl inside {4'd9, 4'd10};
  assign is_div  = MDUControl inside {4'd3, 4'd4};
  assign sa      = MDUControl == 4'd3 && SrcA[WIDTH-1];
  assign sb      = MDUControl == 4'd3 && SrcB[WIDTH-1];
  assign b_zero  = SrcB == '0;
`ifdef MDU_DIVZERO_EN
  assign early_dz = b_zero;
`else
  assign early_dz = 1'b0;
`endif
  // The accumulate happens at accept, so the pipe carries the final {HI,LO} value.
  assign ext_a   = {{WIDTH{mul_s & SrcA[WIDTH-1]}}, SrcA};
  assign ext_b   = {{WIDTH{mul_s & SrcB[WIDTH-1]}}, SrcB};
  assign prod    = ext_a * ext_b;
  assign mul_res = is_madd ? {HI, LO} + prod : is_msub ? {HI, LO} - prod : prod;
  // Partial remainder stays below the divisor, so the diff sign bit is the restore decision.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign ge      = !diff[WIDTH];
  assign q_fin   = dz ? '1 : neg_q ? -quo : quo;
  assign r_fin   = dz ? dvd : neg_r ? -rem : rem;
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = !accept ? IDLE : is_mul ? MUL : is_div ? (early_dz ? FIX : DIV) : IDLE;
    else if (Req)
      state_n = IDLE;
    else if (state == MUL)
      state_n = cnt == CW'(MUL_LAT - 1) ? IDLE : MUL;
    else if (state == DIV)
      state_n = cnt == CW'(WIDTH - 1) ? FIX : DIV;
    else
      state_n = IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      Busy  <= 1'b0;
      cnt   <= '0;
      HI    <= '0;
      LO    <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      dvd   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      for (int i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
`ifdef MDU_DIVZERO_EN
      div_zero <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      Busy    <= state_n != IDLE;
      cnt     <= state_n != state ? '0 : cnt + 1'b1;
      pipe[0] <= mul_res;
      for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
      if (accept && is_div) begin
        rem   <= '0;
        quo   <= sa ? -SrcA : SrcA;
        dvs   <= sb ? -SrcB : SrcB;
        dvd   <= SrcA;
        neg_q <= sa ^ sb;
        neg_r <= sa;
        dz    <= b_zero;
      end else if (state == DIV) begin
        rem <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], ge};
      end
      if (accept && MDUControl == 4'd5) HI <= SrcA;
      if (accept && MDUControl == 4'd6) LO <= SrcA;
      if (state == MUL && state_n == IDLE && !Req) {HI, LO} <= pipe[MUL_LAT-1];
      if (state == FIX && !Req) begin
        HI <= r_fin;
        LO <= q_fin;
`ifdef MDU_DIVZERO_EN
        if (dz) div_zero <= 1'b1;
`endif
      end
    end
  end
endmodule
